// File: rtl/ssm_word_dispatch_if.sv
// ---------------------------------------------------------------------------
// ssm_word_dispatch_if
// Bundles the upstream word stream, the four substream request/serve
// channels and the status outputs of ssm_word_dispatch.
//
// Parameters
//   DEPTH : word-buffer entries (power of two, 8..64)
//   AW    : buffer pointer width, log2(DEPTH)
//
// Signals
//   flush             : synchronous clear of buffer, underflow and counters
//   in_vld / in_data  : upstream 128-bit word and its valid
//   in_rdy            : buffer can take a word this cycle
//   rd_en_ssm0..3     : substream word requests (ssm0 has highest priority)
//   data_ssm0..3      : word served to each substream in the request cycle
//   level             : buffered word count
//   underflow         : sticky flag, a request found no word
//   wcnt_ssm0..3      : words delivered per substream
//
// Modports
//   slave  : the dispatcher side
//   master : the side driving words and requests
// ---------------------------------------------------------------------------
interface ssm_word_dispatch_if #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
);
    logic          flush;
    logic          in_vld;
    logic [127:0]  in_data;
    logic          in_rdy;
    logic          rd_en_ssm0;
    logic          rd_en_ssm1;
    logic          rd_en_ssm2;
    logic          rd_en_ssm3;
    logic [127:0]  data_ssm0;
    logic [127:0]  data_ssm1;
    logic [127:0]  data_ssm2;
    logic [127:0]  data_ssm3;
    logic [AW:0]   level;
    logic          underflow;
    logic [31:0]   wcnt_ssm0;
    logic [31:0]   wcnt_ssm1;
    logic [31:0]   wcnt_ssm2;
    logic [31:0]   wcnt_ssm3;

    modport slave (
        input  flush, in_vld, in_data,
        input  rd_en_ssm0, rd_en_ssm1, rd_en_ssm2, rd_en_ssm3,
        output in_rdy,
        output data_ssm0, data_ssm1, data_ssm2, data_ssm3,
        output level, underflow,
        output wcnt_ssm0, wcnt_ssm1, wcnt_ssm2, wcnt_ssm3
    );

    modport master (
        output flush, in_vld, in_data,
        output rd_en_ssm0, rd_en_ssm1, rd_en_ssm2, rd_en_ssm3,
        input  in_rdy,
        input  data_ssm0, data_ssm1, data_ssm2, data_ssm3,
        input  level, underflow,
        input  wcnt_ssm0, wcnt_ssm1, wcnt_ssm2, wcnt_ssm3
    );
endinterface

// File: rtl/ssm_word_dispatch.sv
// ---------------------------------------------------------------------------
// ssm_word_dispatch
// Circular buffer of DEPTH 128-bit codec words that serves up to four
// substream parsers per cycle. Requests are ranked by substream index: the
// k-th asserted request (counting from ssm0) takes the k-th buffered word,
// if that many words are present. Served words appear combinationally in
// the request cycle; a pushed word becomes servable one cycle later.
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   rstn  : asynchronous active-low reset
//   bus   : ssm_word_dispatch_if.slave (word input, requests, served
//           words, level, underflow, per-substream word counters)
//
// Build option
//   SSM_DISPATCH_STATS_EN : when defined, per-substream served-word
//   counters are built (wrap at 2^32, clear on flush). When undefined the
//   wcnt outputs are tied to zero.
// ---------------------------------------------------------------------------
module ssm_word_dispatch #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    ssm_word_dispatch_if.slave bus
);

    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;

    // Word storage; never reset, only readable once rewritten.
    logic [127:0]  mem_q [DEPTH];

    logic [3:0]    rd_en;
    logic [3:0]    served;
    logic [2:0]    rank [4];
    logic [127:0]  data_w [4];
    logic [2:0]    pops;
    logic          in_rdy;
    logic          push;
    logic          miss;

    // Number of requests from lower-numbered substreams.
    function automatic logic [2:0] req_rank(input logic [3:0] req, input int k);
        logic [2:0] n;
        n = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < k && req[j]) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

    assign rd_en  = {bus.rd_en_ssm3, bus.rd_en_ssm2, bus.rd_en_ssm1, bus.rd_en_ssm0};

    // Readiness is taken from the registered count only; same-cycle pops
    // do not free a slot for a same-cycle push.
    assign in_rdy = (count_q < CW'(DEPTH));
    assign push   = bus.in_vld && in_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ssm
            assign rank[gi]   = req_rank(rd_en, gi);
            // Ranked requests form a prefix, so a request is served exactly
            // when fewer than count words sit ahead of it.
            assign served[gi] = rd_en[gi] && (CW'(rank[gi]) < count_q);
            assign data_w[gi] = served[gi] ? mem_q[rd_ptr_q + AW'(rank[gi])] : '0;
        end
    endgenerate

    // Served requests equal min(requests, count).
    assign pops = 3'(served[0]) + 3'(served[1]) + 3'(served[2]) + 3'(served[3]);
    assign miss = |(rd_en & ~served);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        if (bus.flush) begin
            // Flush wins over any same-cycle push or pop.
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            underflow_d = 1'b0;
        end else begin
            rd_ptr_d    = rd_ptr_q + AW'(pops);
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            // Evaluated at full count width so a push with four pops is exact.
            count_d     = count_q + CW'(push) - CW'(pops);
            underflow_d = underflow_q | miss;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_rdy    = in_rdy;
    assign bus.level     = count_q;
    assign bus.underflow = underflow_q;
    assign bus.data_ssm0 = data_w[0];
    assign bus.data_ssm1 = data_w[1];
    assign bus.data_ssm2 = data_w[2];
    assign bus.data_ssm3 = data_w[3];

`ifdef SSM_DISPATCH_STATS_EN
    logic [31:0] wcnt_q [4];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                wcnt_q[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < 4; i++) begin
                wcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (served[i]) begin
                    wcnt_q[i] <= wcnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign bus.wcnt_ssm0 = wcnt_q[0];
    assign bus.wcnt_ssm1 = wcnt_q[1];
    assign bus.wcnt_ssm2 = wcnt_q[2];
    assign bus.wcnt_ssm3 = wcnt_q[3];
`else
    assign bus.wcnt_ssm0 = '0;
    assign bus.wcnt_ssm1 = '0;
    assign bus.wcnt_ssm2 = '0;
    assign bus.wcnt_ssm3 = '0;
`endif

endmodule

// File: tb/tb_ssm_word_dispatch.sv
// ---------------------------------------------------------------------------
// tb_ssm_word_dispatch
// Bench for ssm_word_dispatch: a hand-computed vector table, directed
// sequences for full/wrap, reset and counters, and a randomized run
// compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ssm_word_dispatch;

    localparam int DEPTH = 16;
`ifdef SSM_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ssm_word_dispatch_if #(.DEPTH(DEPTH)) bus();

    ssm_word_dispatch #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic             fl;
        logic             vld;
        logic [127:0]     d;
        logic [3:0]       rd;
        logic             rdy;
        int               lvl;
        logic             uf;
        logic [3:0][127:0] ed;
    } vec_t;

    vec_t vt [20];

    // Reference model state
    logic [127:0] mq [$];
    logic         uf_m;
    int unsigned  wc_m [4];

    function automatic logic [127:0] W(input int i);
        return {64'h0000_C0DE_0000_0000, 64'(i)};
    endfunction

    function automatic logic [127:0] F(input int i);
        return {64'h0000_F00D_0000_0000, 64'(i)};
    endfunction

    function automatic logic [127:0] dout(input int k);
        case (k)
            0:       return bus.data_ssm0;
            1:       return bus.data_ssm1;
            2:       return bus.data_ssm2;
            default: return bus.data_ssm3;
        endcase
    endfunction

    function automatic logic [31:0] wcnt(input int k);
        case (k)
            0:       return bus.wcnt_ssm0;
            1:       return bus.wcnt_ssm1;
            2:       return bus.wcnt_ssm2;
            default: return bus.wcnt_ssm3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic vld, input logic [127:0] d, input logic [3:0] rd);
        bus.flush      = fl;
        bus.in_vld     = vld;
        bus.in_data    = d;
        bus.rd_en_ssm0 = rd[0];
        bus.rd_en_ssm1 = rd[1];
        bus.rd_en_ssm2 = rd[2];
        bus.rd_en_ssm3 = rd[3];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic fl, input logic vld, input logic [127:0] d,
                                input logic [3:0] rd, input int lvl, input logic uf,
                                input logic [127:0] e0, input logic [127:0] e1,
                                input logic [127:0] e2, input logic [127:0] e3);
        vec_t v;
        v.fl = fl; v.vld = vld; v.d = d; v.rd = rd;
        v.rdy = 1'b1; v.lvl = lvl; v.uf = uf;
        v.ed[0] = e0; v.ed[1] = e1; v.ed[2] = e2; v.ed[3] = e3;
        return v;
    endfunction

    initial begin
        logic [127:0] z;
        logic [127:0] rdata;
        logic [3:0]   rd;
        logic         fl, vld, e_rdy, miss;
        logic [127:0] ed [4];
        int           rank, nserved, p, pv, rp;
        logic         sv [4];

        z = '0;
        drive(1'b0, 1'b0, z, 4'b1111);

        // ---------------- reset state ----------------
        #12;
        chk("rst_rdy", bus.in_rdy, 1'b1);
        chk("rst_lvl", bus.level, 0);
        chk("rst_uf", bus.underflow, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_d%0d", k), dout(k), z);
            chk($sformatf("rst_wc%0d", k), wcnt(k), 0);
        end
        $display("reset: rdy=%0b lvl=%0d uf=%0b", bus.in_rdy, bus.level, bus.underflow);
        drive(1'b0, 1'b0, z, 4'b0000);
        tick();
        rstn = 1'b1;

        // ---------------- vector table ----------------
        vt[0]  = mk(0, 1, W(0),  4'b0000, 0, 0, z, z, z, z);
        vt[1]  = mk(0, 1, W(1),  4'b0000, 1, 0, z, z, z, z);
        vt[2]  = mk(0, 1, W(2),  4'b0000, 2, 0, z, z, z, z);
        vt[3]  = mk(0, 1, W(3),  4'b0000, 3, 0, z, z, z, z);
        vt[4]  = mk(0, 1, W(4),  4'b0000, 4, 0, z, z, z, z);
        vt[5]  = mk(0, 1, W(5),  4'b0000, 5, 0, z, z, z, z);
        vt[6]  = mk(0, 0, z,     4'b1111, 6, 0, W(0), W(1), W(2), W(3));
        vt[7]  = mk(0, 1, W(6),  4'b0000, 2, 0, z, z, z, z);
        vt[8]  = mk(0, 0, z,     4'b1010, 3, 0, z, W(4), z, W(5));
        vt[9]  = mk(0, 1, W(7),  4'b0000, 1, 0, z, z, z, z);
        vt[10] = mk(0, 0, z,     4'b1111, 2, 0, W(6), W(7), z, z);
        vt[11] = mk(0, 0, z,     4'b0000, 0, 1, z, z, z, z);
        vt[12] = mk(0, 1, W(8),  4'b0001, 0, 1, z, z, z, z);
        vt[13] = mk(0, 0, z,     4'b0001, 1, 1, W(8), z, z, z);
        vt[14] = mk(1, 0, z,     4'b0000, 0, 1, z, z, z, z);
        vt[15] = mk(0, 1, W(9),  4'b0001, 0, 0, z, z, z, z);
        vt[16] = mk(0, 1, W(10), 4'b0001, 1, 1, W(9), z, z, z);
        vt[17] = mk(1, 1, W(11), 4'b0001, 1, 1, W(10), z, z, z);
        vt[18] = mk(0, 0, z,     4'b0000, 0, 0, z, z, z, z);
        vt[19] = mk(0, 0, z,     4'b0000, 0, 0, z, z, z, z);

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].fl, vt[i].vld, vt[i].d, vt[i].rd);
            #3;
            chk($sformatf("vec%0d_rdy", i), bus.in_rdy, vt[i].rdy);
            chk($sformatf("vec%0d_lvl", i), bus.level, 128'(vt[i].lvl));
            chk($sformatf("vec%0d_uf", i), bus.underflow, vt[i].uf);
            for (int k = 0; k < 4; k++)
                chk($sformatf("vec%0d_d%0d", i, k), dout(k), vt[i].ed[k]);
            $display("vec %0d: fl=%0b vld=%0b rd=%b lvl=%0d uf=%0b", i, vt[i].fl, vt[i].vld,
                     vt[i].rd, bus.level, bus.underflow);
            tick();
        end

        // ---------------- substream counters ----------------
        drive(1'b1, 1'b0, z, 4'b0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, W(20 + i), 4'b0000);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, z, 4'b0100);
            #3;
            chk($sformatf("cnt_d2_%0d", i), bus.data_ssm2, W(20 + i));
            $display("cnt serve %0d: d2=%h", i, bus.data_ssm2);
            tick();
        end
        drive(1'b0, 1'b0, z, 4'b0000);
        #3;
        for (int k = 0; k < 4; k++)
            chk($sformatf("cnt_wc%0d", k), wcnt(k), (STATS && k == 2) ? 128'd5 : 128'd0);
        chk("cnt_uf", bus.underflow, 1'b0);
        $display("counters: wc0=%0d wc1=%0d wc2=%0d wc3=%0d", bus.wcnt_ssm0, bus.wcnt_ssm1,
                 bus.wcnt_ssm2, bus.wcnt_ssm3);

        // ---------------- full buffer and pointer wrap ----------------
        drive(1'b1, 1'b0, z, 4'b0000);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, F(i), 4'b0000);
            tick();
        end
        drive(1'b0, 1'b1, F(99), 4'b0001);
        #3;
        chk("full_rdy", bus.in_rdy, 1'b0);
        chk("full_lvl", bus.level, 16);
        chk("full_d0", bus.data_ssm0, F(0));
        $display("full: rdy=%0b lvl=%0d d0=%h", bus.in_rdy, bus.level, bus.data_ssm0);
        tick();
        drive(1'b0, 1'b0, z, 4'b0000);
        #3;
        chk("full_after_rdy", bus.in_rdy, 1'b1);
        chk("full_after_lvl", bus.level, 15);
        p = 1;
        for (int i = DEPTH; i < 20; i++) begin
            drive(1'b0, 1'b1, F(i), 4'b0001);
            #3;
            chk($sformatf("wrap_d0_%0d", p), bus.data_ssm0, F(p));
            $display("wrap push %0d pop %0d", i, p);
            p++;
            tick();
        end
        while (p < 20) begin
            drive(1'b0, 1'b0, z, 4'b0001);
            #3;
            chk($sformatf("drain_d0_%0d", p), bus.data_ssm0, F(p));
            $display("drain pop %0d", p);
            p++;
            tick();
        end
        drive(1'b0, 1'b0, z, 4'b0000);
        #3;
        chk("drain_lvl", bus.level, 0);
        chk("drain_uf", bus.underflow, 1'b0);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, W(40 + i), 4'b0000);
            tick();
        end
        drive(1'b0, 1'b1, W(50), 4'b1111);
        #2;
        rstn = 1'b0;
        #2;
        chk("mrst_rdy", bus.in_rdy, 1'b1);
        chk("mrst_lvl", bus.level, 0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("mrst_d%0d", k), dout(k), z);
        $display("mid reset: lvl=%0d", bus.level);
        tick();
        rstn = 1'b1;
        drive(1'b0, 1'b1, W(7), 4'b0000);
        tick();
        drive(1'b0, 1'b0, z, 4'b0001);
        #3;
        chk("mrst_first", bus.data_ssm0, W(7));
        chk("mrst_uf", bus.underflow, 1'b0);
        $display("after reset: d0=%h", bus.data_ssm0);
        tick();

        // ---------------- randomized run vs model ----------------
        drive(1'b1, 1'b0, z, 4'b0000);
        tick();
        mq.delete();
        uf_m = 1'b0;
        for (int k = 0; k < 4; k++) wc_m[k] = 0;
        pv = 60;
        rp = 30;
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) begin
                pv = $urandom_range(15, 95);
                rp = $urandom_range(5, 60);
            end
            fl    = ($urandom_range(0, 99) < 2);
            vld   = ($urandom_range(0, 99) < pv);
            rdata = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 4; k++) rd[k] = ($urandom_range(0, 99) < rp);
            drive(fl, vld, rdata, rd);

            e_rdy   = (mq.size() < DEPTH);
            rank    = 0;
            nserved = 0;
            miss    = 1'b0;
            for (int k = 0; k < 4; k++) begin
                ed[k] = '0;
                sv[k] = 1'b0;
                if (rd[k]) begin
                    if (rank < mq.size()) begin
                        ed[k] = mq[rank];
                        sv[k] = 1'b1;
                        nserved++;
                    end else begin
                        miss = 1'b1;
                    end
                    rank++;
                end
            end

            #3;
            chk($sformatf("rnd%0d_rdy", c), bus.in_rdy, e_rdy);
            chk($sformatf("rnd%0d_lvl", c), bus.level, 128'(mq.size()));
            chk($sformatf("rnd%0d_uf", c), bus.underflow, uf_m);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rnd%0d_d%0d", c, k), dout(k), ed[k]);
                chk($sformatf("rnd%0d_wc%0d", c, k), wcnt(k), 128'(wc_m[k]));
            end
            $display("rnd %0d: fl=%0b vld=%0b rd=%b lvl=%0d served=%0d", c, fl, vld, rd,
                     bus.level, nserved);
            tick();

            if (fl) begin
                mq.delete();
                uf_m = 1'b0;
                for (int k = 0; k < 4; k++) wc_m[k] = 0;
            end else begin
                for (int k = 0; k < nserved; k++) void'(mq.pop_front());
                if (vld && e_rdy) mq.push_back(rdata);
                if (miss) uf_m = 1'b1;
                if (STATS) begin
                    for (int k = 0; k < 4; k++)
                        if (sv[k]) wc_m[k] = wc_m[k] + 1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
